fg_burst_gen: RTL
=================

FG_BURST_GEN -- requirements
Module: fg_burst_gen

Interface
REQ-001 Parameter DEST_WIDTH, default 8, width of the destination field.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 input_fd_valid  input  1  flow descriptor valid (from fg_fd_fifo output).
REQ-005 input_fd_ready  output  1  flow descriptor accepted when high with valid.
REQ-006 input_fd_dest  input  DEST_WIDTH  flow destination.
REQ-007 input_fd_rate_num  input  16  rate numerator (bytes).
REQ-008 input_fd_rate_denom  input  16  rate denominator (cycles).
REQ-009 input_fd_len  input  32  total flow length, bytes.
REQ-010 input_fd_burst_len  input  32  maximum burst length, bytes.
REQ-011 output_bd_valid  output  1  burst descriptor valid.
REQ-012 output_bd_ready  input  1  downstream accepts burst descriptor.
REQ-013 output_bd_dest  output  DEST_WIDTH  burst destination (copy of flow dest).
REQ-014 output_bd_burst_len  output  32  burst length, bytes.
REQ-015 busy  output  1  high while a flow is in progress (state ACTIVE).

Function
REQ-016 FSM states SHALL be IDLE and ACTIVE only.
REQ-017 IDLE: input_fd_ready=1; ACTIVE: input_fd_ready=0.
REQ-018 IDLE, fd handshake: latch dest, rate_num, rate_denom, burst_len; remaining<=len; acc<=0; go ACTIVE; if len==0 stay IDLE, emit nothing.
REQ-019 Effective burst size B = min(remaining, burst_len); burst_len==0 means B = remaining.
REQ-020 Credit accumulator acc SHALL be 49-bit signed; product B*rate_denom computed at 48 bits unsigned, no truncation.
REQ-021 Emission condition: ACTIVE, remaining!=0, acc==0, and output register free (output_bd_valid==0 or output_bd_ready==1 this cycle).
REQ-022 Emission cycle: load output_bd_dest/burst_len=B, assert output_bd_valid next cycle, remaining-=B, acc<=-(B*rate_denom).
REQ-023 Non-emission cycle: acc<=min(acc+rate_num, 0); credit never exceeds zero (no burst banking).
REQ-024 rate_num==0 or rate_denom==0: unthrottled; acc held at 0; emit whenever output register free.
REQ-025 Throttled spacing: consecutive emissions SHALL be exactly ceil(B*rate_denom/rate_num) cycles apart when downstream never stalls.
REQ-026 First burst SHALL be valid the cycle after fd handshake (latency 1).
REQ-027 output_bd_valid and data SHALL hold stable until output_bd_ready; new burst may load in the same cycle the previous is accepted (back-to-back, no bubble).
REQ-028 Return to IDLE in the cycle remaining==0 and output register is empty or being accepted; next fd may be accepted the following cycle.
REQ-029 Sum of emitted burst_len values per flow SHALL equal input_fd_len exactly.

Reset
REQ-030 On rst_n low, immediately: state=IDLE, output_bd_valid=0, output_bd_dest=0, output_bd_burst_len=0, busy=0, acc=0, remaining=0; input_fd_ready=1 after deassertion.
REQ-031 Reset mid-flow SHALL discard the flow and any pending burst descriptor; no partial burst emitted after deassertion.

Structure
REQ-032 Shared package fg_pkg SHALL hold state enum (IDLE, ACTIVE), LEN_WIDTH=32, RATE_WIDTH=16, ACC_WIDTH=49.
REQ-033 One sub-module fg_rate_limiter SHALL contain acc, saturation and emission-eligible output; FSM, remaining counter and output register stay in top.

Verification
REQ-034 Unthrottled: len=1000, burst_len=256, num=0, ready=1 -> bursts 256,256,256,232 on four consecutive cycles starting 1 cycle after handshake, then IDLE.
REQ-035 Throttled: len=300, burst_len=100, num=1, denom=4, ready=1 -> three bursts of 100, spaced exactly 400 cycles.
REQ-036 Backpressure: len=512, burst_len=128, num=0, ready low 10 cycles then high -> first descriptor held stable 10 cycles, remaining three back-to-back, total 512.
REQ-037 Edge: len=0 accepted -> no output_bd_valid, busy stays 0; burst_len=0, len=777 -> single burst 777.
REQ-038 Reset mid-flow: len=1024, burst_len=64, num=1, denom=2, rst_n low after 2nd burst -> outputs zero immediately, no further bursts, new flow len=64 completes normally.
REQ-039 Back-to-back flows: two fds queued, second accepted the cycle after first flow's last burst handshake; dest switches correctly.

Source files
------------

// File: rtl/fg_pkg.sv
// fg_pkg: shared FSM state type and datapath widths for the flow-generator burst path.
package fg_pkg;
    typedef enum logic {IDLE, ACTIVE} state_t;
    localparam int LEN_WIDTH  = 32;
    localparam int RATE_WIDTH = 16;
    localparam int ACC_WIDTH  = 49;
    localparam int PROD_WIDTH = LEN_WIDTH + RATE_WIDTH;
endpackage

// File: rtl/fg_rate_limiter.sv
// fg_rate_limiter: signed credit accumulator gating burst emission to rate_num/rate_denom bytes per cycle.
module fg_rate_limiter
    import fg_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_clear,
    input  logic                  i_emit,
    input  logic [LEN_WIDTH-1:0]  i_burst,
    input  logic [RATE_WIDTH-1:0] i_num,
    input  logic [RATE_WIDTH-1:0] i_denom,
    output logic                  o_eligible
);
    logic signed [ACC_WIDTH-1:0] r_acc;
    logic signed [ACC_WIDTH-1:0] w_base;
    logic signed [ACC_WIDTH-1:0] w_sum;
    logic [PROD_WIDTH-1:0]       w_prod;
    logic                        w_unthrottled;
    // The emission cycle itself earns one cycle of credit, so bursts land exactly ceil(B*denom/num) cycles apart.
    always_comb begin
        w_unthrottled = (i_num == '0) || (i_denom == '0);
        w_prod        = PROD_WIDTH'(i_burst) * PROD_WIDTH'(i_denom);
        w_base        = i_emit ? -$signed({1'b0, w_prod}) : r_acc;
        w_sum         = w_base + $signed({{(ACC_WIDTH-RATE_WIDTH){1'b0}}, i_num});
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_acc <= '0;
        else if (w_unthrottled || (i_clear && !i_emit))
            r_acc <= '0;
        else
            r_acc <= (w_sum > 0) ? '0 : w_sum;
    end
    assign o_eligible = (r_acc == '0);
endmodule

// File: rtl/fg_burst_gen.sv
// fg_burst_gen: splits accepted flow descriptors into rate-limited burst descriptors.
module fg_burst_gen
    import fg_pkg::*;
#(
    parameter int DEST_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  input_fd_valid,
    output logic                  input_fd_ready,
    input  logic [DEST_WIDTH-1:0] input_fd_dest,
    input  logic [RATE_WIDTH-1:0] input_fd_rate_num,
    input  logic [RATE_WIDTH-1:0] input_fd_rate_denom,
    input  logic [LEN_WIDTH-1:0]  input_fd_len,
    input  logic [LEN_WIDTH-1:0]  input_fd_burst_len,
    output logic                  output_bd_valid,
    input  logic                  output_bd_ready,
    output logic [DEST_WIDTH-1:0] output_bd_dest,
    output logic [LEN_WIDTH-1:0]  output_bd_burst_len,
    output logic                  busy
);
    state_t                r_state;
    logic [DEST_WIDTH-1:0] r_dest;
    logic [RATE_WIDTH-1:0] r_num;
    logic [RATE_WIDTH-1:0] r_denom;
    logic [LEN_WIDTH-1:0]  r_blen;
    logic [LEN_WIDTH-1:0]  r_rem;
    logic                  r_bd_valid;
    logic [DEST_WIDTH-1:0] r_bd_dest;
    logic [LEN_WIDTH-1:0]  r_bd_len;
    logic                  w_idle;
    logic                  w_hs;
    logic                  w_free;
    logic                  w_elig;
    logic                  w_emit;
    logic [LEN_WIDTH-1:0]  w_rem;
    logic [LEN_WIDTH-1:0]  w_blen;
    logic [LEN_WIDTH-1:0]  w_b;
    logic [RATE_WIDTH-1:0] w_num;
    logic [RATE_WIDTH-1:0] w_denom;
    // In IDLE the incoming descriptor feeds the datapath directly so the first burst loads on the handshake edge.
    always_comb begin
        w_idle  = (r_state == IDLE);
        w_hs    = w_idle && input_fd_valid;
        w_free  = !r_bd_valid || output_bd_ready;
        w_rem   = w_idle ? input_fd_len : r_rem;
        w_blen  = w_idle ? input_fd_burst_len : r_blen;
        w_num   = w_idle ? input_fd_rate_num : r_num;
        w_denom = w_idle ? input_fd_rate_denom : r_denom;
        w_b     = (w_blen == '0 || w_rem < w_blen) ? w_rem : w_blen;
        w_emit  = w_idle ? (w_hs && input_fd_len != '0) : (r_rem != '0 && w_elig && w_free);
    end
    fg_rate_limiter u_rate (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_clear    (w_idle),
        .i_emit     (w_emit),
        .i_burst    (w_b),
        .i_num      (w_num),
        .i_denom    (w_denom),
        .o_eligible (w_elig)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_dest     <= '0;
            r_num      <= '0;
            r_denom    <= '0;
            r_blen     <= '0;
            r_rem      <= '0;
            r_bd_valid <= 1'b0;
            r_bd_dest  <= '0;
            r_bd_len   <= '0;
        end else begin
            if (w_emit) begin
                r_bd_valid <= 1'b1;
                r_bd_dest  <= w_idle ? input_fd_dest : r_dest;
                r_bd_len   <= w_b;
                r_rem      <= w_rem - w_b;
            end else if (output_bd_ready) begin
                r_bd_valid <= 1'b0;
            end
            if (w_hs) begin
                r_dest  <= input_fd_dest;
                r_num   <= input_fd_rate_num;
                r_denom <= input_fd_rate_denom;
                r_blen  <= input_fd_burst_len;
                r_state <= (input_fd_len != '0) ? ACTIVE : IDLE;
            end else if (!w_idle && r_rem == '0 && w_free) begin
                r_state <= IDLE;
            end
        end
    end
    assign input_fd_ready      = w_idle;
    assign busy                = !w_idle;
    assign output_bd_valid     = r_bd_valid;
    assign output_bd_dest      = r_bd_dest;
    assign output_bd_burst_len = r_bd_len;
endmodule
